// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/arith ops, serial shifts.
// Define ALU_MUL_EN to build the serial shift-add multiplier (op 8); otherwise op 8 is illegal.
//   state | meaning
//   IDLE  | in_ready high, waiting for an op
//   EXEC  | computing (1 cycle, shamt cycles for shifts, WIDTH cycles for MUL)
//   DONE  | out_valid high, result held until out_ready
module alu_mc #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_SLL = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           st, st_nxt;
  logic [3:0]       op_q, op_nxt;
  logic [WIDTH-1:0] a_q, a_nxt, b_q, b_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] res_nxt, hi_nxt;
  logic             cout_nxt, ovf_nxt, ill_nxt, commit;
  logic [WIDTH:0]   add_s, sub_s;
  logic             add_ovf, sub_ovf;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   acc_hi, acch_nxt;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mcat;
`endif

  assign add_s   = {1'b0, a_q} + {1'b0, b_q};
  assign sub_s   = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
  assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]);
  assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_s[WIDTH-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt   = st;
    op_nxt   = op_q;
    a_nxt    = a_q;
    b_nxt    = b_q;
    acc_nxt  = acc;
    cnt_nxt  = cnt;
    res_nxt  = '0;
    hi_nxt   = '0;
    cout_nxt = 1'b0;
    ovf_nxt  = 1'b0;
    ill_nxt  = 1'b0;
    commit   = 1'b0;
`ifdef ALU_MUL_EN
    acch_nxt = acc_hi;
    msum     = '0;
    mcat     = '0;
`endif
    case (st)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_nxt  = op;
          a_nxt   = a;
          b_nxt   = b;
          acc_nxt = a;
          cnt_nxt = CW'(b[SHW-1:0]);
`ifdef ALU_MUL_EN
          // multiplier starts in the low half of the product register
          if (op == OP_MUL) begin
            acc_nxt  = b;
            acch_nxt = '0;
            cnt_nxt  = CW'(WIDTH);
          end
`endif
          st_nxt = EXEC;
        end
      end
      EXEC: begin
        commit = 1'b1;
        case (op_q)
          OP_ADD: begin res_nxt = add_s[WIDTH-1:0]; cout_nxt = add_s[WIDTH]; ovf_nxt = add_ovf; end
          OP_SUB: begin res_nxt = sub_s[WIDTH-1:0]; cout_nxt = sub_s[WIDTH]; ovf_nxt = sub_ovf; end
          OP_NOT: res_nxt = ~a_q;
          OP_AND: res_nxt = a_q & b_q;
          OP_OR:  res_nxt = a_q | b_q;
          OP_XOR: res_nxt = a_q ^ b_q;
          OP_SLT: begin res_nxt = WIDTH'(sub_s[WIDTH-1] ^ sub_ovf); ovf_nxt = sub_ovf; end
          OP_EQ:  res_nxt = WIDTH'(sub_s[WIDTH-1:0] == '0);
          OP_SLL, OP_SRL, OP_SRA: begin
            if (cnt != '0) begin
              if (op_q == OP_SLL)      acc_nxt = acc << 1;
              else if (op_q == OP_SRL) acc_nxt = acc >> 1;
              else                     acc_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
              cnt_nxt = cnt - CW'(1);
            end
            res_nxt = acc_nxt;
            commit  = (cnt <= CW'(1));
          end
`ifdef ALU_MUL_EN
          OP_MUL: begin
            msum     = acc[0] ? ({1'b0, acc_hi} + {1'b0, a_q}) : {1'b0, acc_hi};
            mcat     = {msum, acc[WIDTH-1:1]};
            acch_nxt = mcat[2*WIDTH-1:WIDTH];
            acc_nxt  = mcat[WIDTH-1:0];
            cnt_nxt  = cnt - CW'(1);
            res_nxt  = acc_nxt;
            hi_nxt   = acch_nxt;
            commit   = (cnt == CW'(1));
          end
`endif
          default: ill_nxt = 1'b1;
        endcase
        if (commit) st_nxt = DONE;
      end
      DONE: if (out_ready) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      op_q      <= op_nxt;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      in_ready  <= (st_nxt == IDLE);
      out_valid <= (st_nxt == DONE);
      // outputs only move when an op finishes, so DONE holds them untouched
      if (commit) begin
        result    <= res_nxt;
        result_hi <= hi_nxt;
        cout      <= cout_nxt;
        overflow  <= ovf_nxt;
        zero      <= (res_nxt == '0);
        illegal   <= ill_nxt;
      end
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_hi <= '0;
    else      acc_hi <= acch_nxt;
  end
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=4); expectations come from an arithmetic model.
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_mc;
  localparam int W = 4;
  localparam int M = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         cout, overflow, zero, illegal;
  logic [3:0]   op;
  logic [W-1:0] a, b, result, result_hi;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .cout(cout), .overflow(overflow), .zero(zero), .illegal(illegal)
  );

  function automatic int sgn(input int x);
    return (x >= M/2) ? x - M : x;
  endfunction

  // returns expected result, high half, carry, overflow, illegal and accept->out_valid latency
  function automatic void model(input int o, input int x, input int y, output int r, output int h,
                                output int c, output int v, output int il, output int lat);
    int sx, sy, sh, p;
    sx = sgn(x); sy = sgn(y); sh = y % W;
    r = 0; h = 0; c = 0; v = 0; il = 0; lat = 2;
    case (o)
      0: begin p = x + y; r = p % M; c = (p >= M); v = (sx + sy > M/2 - 1) || (sx + sy < -M/2); end
      1: begin p = x - y; r = (p + M) % M; c = (x >= y); v = (sx - sy > M/2 - 1) || (sx - sy < -M/2); end
      2: r = (M - 1) - x;
      3: r = x & y;
      4: r = x | y;
      5: r = x ^ y;
      6: begin r = (sx < sy); v = (sx - sy > M/2 - 1) || (sx - sy < -M/2); end
      7: r = (x == y);
      8: begin
`ifdef ALU_MUL_EN
        p = x * y; r = p % M; h = p / M; lat = 1 + W;
`else
        il = 1;
`endif
      end
      9:  begin r = (x << sh) % M; lat = 1 + ((sh > 0) ? sh : 1); end
      10: begin r = x >> sh;       lat = 1 + ((sh > 0) ? sh : 1); end
      11: begin r = ((sx >>> sh) + M) % M; lat = 1 + ((sh > 0) ? sh : 1); end
      default: il = 1;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output bit to);
    int k;
    to = 0; k = 0; lat = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) to = 1;
    else begin
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
      lat = 1;
      while (lat < 60) begin
        @(negedge clk);
        if (out_valid) break;
        @(posedge clk);
        lat++;
      end
      if (!out_valid) to = 1;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #22;
    n_checks++;
    if ({in_ready, out_valid, cout, overflow, zero, illegal, result, result_hi} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h hi=%h c=%b v=%b z=%b il=%b, want all 0",
               in_ready, out_valid, result, result_hi, cout, overflow, zero, illegal);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b want 1", in_ready);
    end
  endtask

  typedef struct {
    logic [3:0] o;
    int x, y, r, h, c, v, il, lat;
  } vec_t;

  task automatic test_directed();
    vec_t dv[$];
    int lat;
    bit to;
    logic [2*W+3:0] got, exp_v;
    dv.push_back('{4'd0, 7, 1, 8, 0, 0, 1, 0, 2});
    dv.push_back('{4'd1, 3, 5, 14, 0, 0, 0, 0, 2});
    dv.push_back('{4'd6, 3, 5, 1, 0, 0, 0, 0, 2});
    dv.push_back('{4'd7, 9, 9, 1, 0, 0, 0, 0, 2});
`ifdef ALU_MUL_EN
    dv.push_back('{4'd8, 7, 6, 10, 2, 0, 0, 0, 5});
`else
    dv.push_back('{4'd8, 7, 6, 0, 0, 0, 0, 1, 2});
`endif
    dv.push_back('{4'd11, 8, 2, 14, 0, 0, 0, 0, 3});
    dv.push_back('{4'd9, 3, 0, 3, 0, 0, 0, 0, 2});
    dv.push_back('{4'd10, 8, 3, 1, 0, 0, 0, 0, 4});
    dv.push_back('{4'd1, 5, 3, 2, 0, 1, 0, 0, 2});
    dv.push_back('{4'd0, 9, 7, 0, 0, 1, 0, 0, 2});
    dv.push_back('{4'd2, 5, 0, 10, 0, 0, 0, 0, 2});
    dv.push_back('{4'd13, 5, 3, 0, 0, 0, 0, 1, 2});
    foreach (dv[i]) begin
      do_op(dv[i].o, W'(dv[i].x), W'(dv[i].y), lat, to);
      exp_v = {W'(dv[i].r), W'(dv[i].h), dv[i].c[0], dv[i].v[0], (dv[i].r == 0), dv[i].il[0]};
      got   = {result, result_hi, cout, overflow, zero, illegal};
      n_checks++;
      if (to || lat != dv[i].lat) begin
        n_fail++;
        $display("FAIL dir_latency op=%0d: got %0d (timeout=%0b) want %0d", dv[i].o, lat, to, dv[i].lat);
      end
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL dir_outputs op=%0d a=%0d b=%0d: got res/hi/c/v/z/il=%h want %h",
                 dv[i].o, dv[i].x, dv[i].y, got, exp_v);
      end
      retire();
    end
  endtask

  task automatic test_random();
    int o, x, y, r, h, c, v, il, elat, lat, d;
    bit to;
    logic [2*W+3:0] got, exp_v;
    for (int i = 0; i < 60; i++) begin
      o = $urandom_range(0, 15); x = $urandom_range(0, M-1); y = $urandom_range(0, M-1);
      model(o, x, y, r, h, c, v, il, elat);
      do_op(4'(o), W'(x), W'(y), lat, to);
      exp_v = {W'(r), W'(h), c[0], v[0], (r == 0), il[0]};
      got   = {result, result_hi, cout, overflow, zero, illegal};
      n_checks++;
      if (to || lat != elat) begin
        n_fail++;
        $display("FAIL rnd_latency op=%0d b=%0d: got %0d (timeout=%0b) want %0d", o, y, lat, to, elat);
      end
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL rnd_outputs op=%0d a=%0d b=%0d: got %h want %h", o, x, y, got, exp_v);
      end
      d = $urandom_range(0, 2);
      repeat (d) @(negedge clk);
      retire();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_retire: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit to;
    logic [2*W+3:0] got, exp_v;
    do_op(4'd0, 4'd6, 4'd5, lat, to);
    exp_v = {4'hB, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      // a new op offered while DONE must be ignored
      in_valid = 1'b1; op = 4'd2; a = 4'd1; b = 4'd1;
      @(posedge clk);
      #1;
      got = {result, result_hi, cout, overflow, zero, illegal};
      n_checks++;
      if (to || out_valid !== 1'b1 || in_ready !== 1'b0 || got !== exp_v) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: got vld=%b rdy=%b out=%h want vld=1 rdy=0 out=%h",
                 k, out_valid, in_ready, got, exp_v);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_accept: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bit to;
    @(negedge clk);
    op = 4'd8; a = 4'd7; b = 4'd6; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, cout, overflow, zero, illegal, result, result_hi} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: got rdy=%b vld=%b res=%h hi=%h flags=%b%b%b%b want all 0",
               in_ready, out_valid, result, result_hi, cout, overflow, zero, illegal);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_restart: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    do_op(4'd13, 4'd3, 4'd4, lat, to);
    n_checks++;
    if (to || lat != 2 || illegal !== 1'b1 || result !== 4'h0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_illegal: got lat=%0d il=%b res=%h z=%b want lat=2 il=1 res=0 z=1",
               lat, illegal, result, zero);
    end
    retire();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
